// File: rtl/sound_sequencer.sv
// Step sequencer feeding the sound generator's parameter inputs.
// Plays a host-written step table, holding each entry for a tick count.
module sound_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [49:0]   wr_data,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic          stop,
    output logic [9:0]    lfo_freq,
    output logic [11:0]   noise_freq,
    output logic [11:0]   vco_freq,
    output logic          vco_select,
    output logic          noise_select,
    output logic [2:0]    lfo_shift,
    output logic [2:0]    mixer,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] step_addr
);

    typedef enum logic [1:0] {IDLE, FETCH, LATCH, PLAY} state_t;

    state_t      state;
    state_t      state_next;
    logic [49:0] mem [DEPTH];
    logic [49:0] rd_data;
    logic [7:0]  dur_cnt;

    logic load;
    logic finish;
    logic halt;
    logic restart;
    logic advance;
    logic count;

    // Table is never reset; read always tracks step_addr so FETCH needs no strobe.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[step_addr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        finish     = 1'b0;
        halt       = 1'b0;
        restart    = 1'b0;
        advance    = 1'b0;
        count      = 1'b0;
        if (stop) begin
            state_next = IDLE;
            halt       = 1'b1;
        end else if (start) begin
            state_next = FETCH;
            restart    = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                end
                FETCH: begin
                    state_next = LATCH;
                end
                LATCH: begin
                    if (rd_data[49:42] == 8'd0) begin
                        state_next = IDLE;
                        finish     = 1'b1;
                    end else begin
                        state_next = PLAY;
                        load       = 1'b1;
                    end
                end
                PLAY: begin
                    if (tick) begin
                        count = 1'b1;
                        if (dur_cnt == 8'd1) begin
                            state_next = FETCH;
                            advance    = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Parameters hold across FETCH/LATCH so steps chain without a silent gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfo_freq     <= '0;
            noise_freq   <= '0;
            vco_freq     <= '0;
            vco_select   <= 1'b0;
            noise_select <= 1'b0;
            lfo_shift    <= '0;
            mixer        <= '0;
            done         <= 1'b0;
            step_addr    <= '0;
            dur_cnt      <= '0;
        end else begin
            done <= finish;
            if (halt || finish) begin
                mixer <= '0;
            end
            if (restart) begin
                step_addr <= start_addr;
            end
            if (advance) begin
                step_addr <= step_addr + AW'(1);
            end
            if (load) begin
                dur_cnt      <= rd_data[49:42];
                vco_freq     <= rd_data[41:30];
                noise_freq   <= rd_data[29:18];
                lfo_freq     <= rd_data[17:8];
                lfo_shift    <= rd_data[7:5];
                mixer        <= rd_data[4:2];
                vco_select   <= rd_data[1];
                noise_select <= rd_data[0];
            end
            if (count) begin
                dur_cnt <= dur_cnt - 8'd1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sound_sequencer.sv
// Bench for sound_sequencer: per-cycle model compare plus
// hand-computed literal checks on directed scenarios.
module tb_sound_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [49:0] wr_data;
    logic        start;
    logic [3:0]  start_addr;
    logic        stop;
    logic [9:0]  lfo_freq;
    logic [11:0] noise_freq;
    logic [11:0] vco_freq;
    logic        vco_select;
    logic        noise_select;
    logic [2:0]  lfo_shift;
    logic [2:0]  mixer;
    logic        busy;
    logic        done;
    logic [3:0]  step_addr;

    int n_chk  = 0;
    int n_pass = 0;

    sound_sequencer #(.DEPTH(16), .AW(4)) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .start_addr(start_addr), .stop(stop),
        .lfo_freq(lfo_freq), .noise_freq(noise_freq),
        .vco_freq(vco_freq), .vco_select(vco_select),
        .noise_select(noise_select), .lfo_shift(lfo_shift),
        .mixer(mixer), .busy(busy), .done(done),
        .step_addr(step_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %h want %h", name, got, exp);
    endtask

    function automatic logic [49:0] pack(input int d, input int vco,
        input int nz, input int lfo, input int sh, input int mx,
        input int vs, input int ns);
        return {8'(d), 12'(vco), 12'(nz), 10'(lfo), 3'(sh), 3'(mx),
                1'(vs), 1'(ns)};
    endfunction

    // Model: a step is fetched two edges after it is requested, then
    // held for its duration in ticks seen while playing.
    logic [49:0] tmem [16];
    logic [49:0] m_ent;
    logic [49:0] m_snap;
    logic [2:0]  m_mix;
    logic        m_busy;
    logic        m_done;
    logic [3:0]  m_addr;
    logic        m_play;
    int          m_wait;
    int          m_left;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ent  <= '0;
            m_snap <= '0;
            m_mix  <= '0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_addr <= '0;
            m_play <= 1'b0;
            m_wait <= 0;
            m_left <= 0;
        end else begin
            if (wr_en) tmem[wr_addr] <= wr_data;
            m_done <= 1'b0;
            if (stop) begin
                m_busy <= 1'b0;
                m_mix  <= '0;
                m_wait <= 0;
                m_play <= 1'b0;
            end else if (start) begin
                m_busy <= 1'b1;
                m_addr <= start_addr;
                m_wait <= 2;
                m_play <= 1'b0;
            end else if (m_wait == 2) begin
                m_snap <= tmem[m_addr];
                m_wait <= 1;
            end else if (m_wait == 1) begin
                m_wait <= 0;
                if (m_snap[49:42] == 8'd0) begin
                    m_mix  <= '0;
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                end else begin
                    m_ent  <= m_snap;
                    m_mix  <= m_snap[4:2];
                    m_left <= int'(m_snap[49:42]);
                    m_play <= 1'b1;
                end
            end else if (m_play && tick) begin
                if (m_left == 1) begin
                    m_play <= 1'b0;
                    m_addr <= m_addr + 4'd1;
                    m_wait <= 2;
                end else begin
                    m_left <= m_left - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("cycle",
                {vco_freq, noise_freq, lfo_freq, lfo_shift, mixer,
                 vco_select, noise_select, busy, done, step_addr},
                {m_ent[41:30], m_ent[29:18], m_ent[17:8], m_ent[7:5],
                 m_mix, m_ent[1], m_ent[0], m_busy, m_done, m_addr});
        end
    end

    task automatic wr(input int a, input logic [49:0] d);
        wr_en   = 1'b1;
        wr_addr = 4'(a);
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic go(input int a);
        start      = 1'b1;
        start_addr = 4'(a);
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic tick1();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1);
    endtask

    initial begin
        reset = 1'b1; tick = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
        start = 0; start_addr = 0; stop = 0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {vco_freq, noise_freq, lfo_freq, mixer, busy,
                         done, step_addr}, 0);
        reset = 1'b0;

        // single step then end marker
        wr(0, pack(3, 250, 90, 1000, 1, 3, 1, 1));
        wr(1, 50'd0);
        go(0);
        @(negedge clk);
        chk("t1_early_mix", mixer, 0);
        @(negedge clk);
        chk("t1_vco", vco_freq, 250);
        chk("t1_noise", noise_freq, 90);
        chk("t1_lfo", lfo_freq, 1000);
        chk("t1_misc", {lfo_shift, mixer, vco_select, noise_select},
            {3'd1, 3'd3, 1'b1, 1'b1});
        tick1(); @(negedge clk);
        tick1(); @(negedge clk);
        chk("t1_hold", {mixer, step_addr, busy}, {3'd3, 4'd0, 1'b1});
        tick1();
        chk("t1_addr", step_addr, 1);
        @(negedge clk);
        @(negedge clk);
        chk("t1_end", {done, busy, mixer, step_addr},
            {1'b1, 1'b0, 3'd0, 4'd1});
        @(negedge clk);
        chk("t1_done_1cyc", done, 0);

        // two-step chain
        wr(2, pack(1, 100, 20, 30, 2, 5, 0, 1));
        wr(3, pack(2, 200, 40, 50, 3, 6, 1, 0));
        wr(4, 50'd0);
        go(2);
        @(negedge clk); @(negedge clk);
        chk("t2_a", {vco_freq, mixer}, {12'd100, 3'd5});
        tick1();
        chk("t2_gap0", {mixer, step_addr}, {3'd5, 4'd3});
        @(negedge clk);
        chk("t2_gap1", mixer, 5);
        @(negedge clk);
        chk("t2_b", {vco_freq, mixer}, {12'd200, 3'd6});
        tick1(); @(negedge clk);
        tick1();
        wait_done();

        // ticks held high through FETCH/LATCH
        @(negedge clk);
        start = 1'b1; tick = 1'b1; start_addr = 4'd2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("t3_load", {step_addr, vco_freq}, {4'd2, 12'd100});
        @(negedge clk);
        chk("t3_adv", step_addr, 3);
        wait_done();
        tick = 1'b0;

        // full table, no end marker, wrap from 15
        for (int i = 0; i < 16; i++)
            wr(i, pack(1, i * 16 + 5, i, i, i % 8, (i % 7) + 1,
                       i % 2, 1 - (i % 2)));
        start = 1'b1; tick = 1'b1; start_addr = 4'd15;
        @(negedge clk);
        start = 1'b0;
        chk("t4_addr15", step_addr, 15);
        @(negedge clk); @(negedge clk);
        chk("t4_vco15", vco_freq, 245);
        @(negedge clk);
        chk("t4_wrap0", step_addr, 0);
        @(negedge clk); @(negedge clk);
        chk("t4_vco0", vco_freq, 5);
        @(negedge clk);
        chk("t4_addr1", step_addr, 1);
        repeat (50) @(negedge clk);
        chk("t4_busy", busy, 1);
        tick = 1'b0;

        // stop beats start
        repeat (3) @(negedge clk);
        stop = 1'b1; start = 1'b1; start_addr = 4'd3;
        @(negedge clk);
        stop = 1'b0; start = 1'b0;
        chk("t5_stop", {mixer, busy, done}, 0);
        @(negedge clk);
        chk("t5_quiet", {busy, done}, 0);
        go(0);
        @(negedge clk); @(negedge clk);
        chk("t5_restart", {vco_freq, mixer}, {12'd5, 3'd1});
        go(5);
        chk("t5_re_addr", step_addr, 5);
        @(negedge clk); @(negedge clk);
        chk("t5_re_vals", {vco_freq, mixer}, {12'd85, 3'd6});

        // async reset mid-cycle
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("t6_async", {vco_freq, noise_freq, lfo_freq, lfo_shift,
                            mixer, vco_select, noise_select, busy, done,
                            step_addr}, 0);
        @(negedge clk);
        reset = 1'b0;
        go(0);
        @(negedge clk); @(negedge clk);
        chk("t6_replay", {vco_freq, mixer}, {12'd5, 3'd1});
        tick = 1'b1;
        repeat (20) @(negedge clk);
        tick = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
